// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU has priority, DMA gets a starvation slot
// and may lock the RAM for bursts. Optional perf counters are enabled by ARB_PERF_CNT_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    input  logic              dma_last_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       cpu_stall_cnt_o,
    output logic [31:0]       dma_beat_cnt_o
`endif
);

    localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int unsigned BeatW = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(MAX_WAIT);
    localparam logic [BeatW-1:0] BurstMax = BeatW'(BURST_MAX);

    typedef enum logic [0:0] {StIdle, StDma} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic             rd_pending_q, rd_pending_d;
    logic             rd_owner_q, rd_owner_d;
    logic             dma_prio;

    assign dma_prio = dma_req_i && (wait_q == WaitMax);

    // Grants are forced low while rst_n is asserted so every output reads 0 in reset.
    always_comb begin
        cpu_gnt_o = 1'b0;
        dma_gnt_o = 1'b0;
        state_d   = state_q;
        beat_d    = beat_q;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_req_i && !dma_prio) begin
                        cpu_gnt_o = 1'b1;
                    end else if (dma_req_i) begin
                        dma_gnt_o = 1'b1;
                        if (!dma_last_i && (BURST_MAX > 1)) begin
                            state_d = StDma;
                            beat_d  = BeatW'(1);
                        end
                    end
                end
                StDma: begin
                    if (dma_req_i) begin
                        dma_gnt_o = 1'b1;
                        beat_d    = beat_q + BeatW'(1);
                        if (dma_last_i || (beat_d == BurstMax)) begin
                            state_d = StIdle;
                            beat_d  = '0;
                        end
                    end else begin
                        // DMA dropped its request mid-burst: release the lock at once.
                        cpu_gnt_o = cpu_req_i;
                        state_d   = StIdle;
                        beat_d    = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    beat_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!dma_req_i || dma_gnt_o) begin
            wait_d = '0;
        end else if (wait_q != WaitMax) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    assign rd_pending_d = (cpu_gnt_o && !cpu_we_i) || (dma_gnt_o && !dma_we_i);
    assign rd_owner_d   = dma_gnt_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            beat_q       <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            beat_q       <= beat_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign cpu_stall_o = cpu_req_i && !cpu_gnt_o && rst_n;
    assign mem_en_o    = cpu_gnt_o || dma_gnt_o;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (cpu_gnt_o) begin
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (dma_gnt_o) begin
            mem_we_o    = dma_we_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
        end
    end

    assign cpu_rvalid_o = rd_pending_q && !rd_owner_q;
    assign dma_rvalid_o = rd_pending_q && rd_owner_q;
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
    assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] dma_beats_q, dma_beats_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        dma_beats_d = dma_beats_q;
        if (cpu_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (dma_gnt_o && (dma_beats_q != '1)) begin
            dma_beats_d = dma_beats_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            dma_beats_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            dma_beats_q <= dma_beats_d;
        end
    end

    assign cpu_stall_cnt_o = stall_cnt_q;
    assign dma_beat_cnt_o  = dma_beats_q;
`endif

endmodule
